// File: rtl/bru_pkg.sv
// Shared definitions for the branch resolve unit.
// Condition codes, FSM states and default flush length.
package bru_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam int FLUSH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_FLUSH
    } bru_state_t;

endpackage

// File: rtl/branch_cond_decode.sv
// Combinational branch condition decode.
// Uses comparator flags exactly as presented.
module branch_cond_decode (
    input  logic       is_branch,
    input  logic [2:0] funct3,
    input  logic       greater,
    input  logic       equal,
    input  logic       less,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);
    import bru_pkg::*;

    // Map funct3 to a direction; reserved codes flag illegal
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (is_branch) begin
            case (funct3)
                BEQ:     taken = equal;
                BNE:     taken = !equal;
                BLT:     taken = less;
                BGE:     taken = greater | equal;
                BLTU:    taken = ltu;
                BGEU:    taken = !ltu;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: decode, registered result, redirect/flush FSM.
// Optional BRU_STATS_EN adds a saturating mispredict counter.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  is_branch,
    input  logic [2:0]            funct3,
    input  logic                  pred_taken,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  greater,
    input  logic                  equal,
    input  logic                  less,
    input  logic                  ltu,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  taken,
    output logic                  illegal,
    output logic [DATA_WIDTH-1:0] target,
    output logic                  redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
`ifdef BRU_STATS_EN
    output logic [15:0]           mispredict_cnt,
`endif
    output logic                  flush
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    bru_state_t state_q;
    bru_state_t state_d;
    logic [3:0] cnt_q;
    logic       mp_q;

    logic dec_taken;
    logic dec_illegal;
    logic mispredict;
    logic accept;
    logic hs_flush;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] seq_pc;

    branch_cond_decode u_dec (
        .is_branch (is_branch),
        .funct3    (funct3),
        .greater   (greater),
        .equal     (equal),
        .less      (less),
        .ltu       (ltu),
        .taken     (dec_taken),
        .illegal   (dec_illegal)
    );

    assign sum        = pc + imm;
    assign seq_pc     = pc + DATA_WIDTH'(4);
    assign mispredict = dec_taken ^ pred_taken;
    assign accept     = in_valid && in_ready;
    assign hs_flush   = (state_q == ST_HOLD) && out_ready && mp_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (mp_q)        state_d = ST_FLUSH;
                    else if (accept) state_d = ST_HOLD;
                    else             state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and flush outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        flush     = 1'b0;
        case (state_q)
            ST_IDLE:  in_ready = 1'b1;
            ST_HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !mp_q;
            end
            ST_FLUSH: flush = 1'b1;
            default:  in_ready = 1'b0;
        endcase
    end

    // Flush length counter, loaded when a mispredict is handed off
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (hs_flush) begin
            cnt_q <= FLUSH_LOAD;
        end else if (state_q == ST_FLUSH && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    // Result registers; redirect pulses only on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            taken       <= 1'b0;
            illegal     <= 1'b0;
            target      <= '0;
            redirect_pc <= '0;
            redirect    <= 1'b0;
            mp_q        <= 1'b0;
        end else begin
            redirect <= 1'b0;
            if (accept) begin
                taken       <= dec_taken;
                illegal     <= dec_illegal;
                target      <= sum;
                redirect_pc <= dec_taken ? sum : seq_pc;
                redirect    <= mispredict;
                mp_q        <= mispredict;
            end
        end
    end

`ifdef BRU_STATS_EN
    // Saturating count of accepted mispredicting packets
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_cnt <= 16'd0;
        end else if (accept && mispredict && mispredict_cnt != 16'hFFFF) begin
            mispredict_cnt <= mispredict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit.
// Directed cases followed by random transactions vs a reference model.
module tb_branch_resolve_unit;

    localparam int DW = 32;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          is_branch;
    logic [2:0]    funct3;
    logic          pred_taken;
    logic [DW-1:0] pc;
    logic [DW-1:0] imm;
    logic          greater;
    logic          equal;
    logic          less;
    logic          ltu;
    logic          out_valid;
    logic          out_ready;
    logic          taken;
    logic          illegal;
    logic [DW-1:0] target;
    logic          redirect;
    logic [DW-1:0] redirect_pc;
    logic          flush;
`ifdef BRU_STATS_EN
    logic [15:0]   mispredict_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    branch_resolve_unit #(
        .DATA_WIDTH   (DW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .is_branch      (is_branch),
        .funct3         (funct3),
        .pred_taken     (pred_taken),
        .pc             (pc),
        .imm            (imm),
        .greater        (greater),
        .equal          (equal),
        .less           (less),
        .ltu            (ltu),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .taken          (taken),
        .illegal        (illegal),
        .target         (target),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
`ifdef BRU_STATS_EN
        .mispredict_cnt (mispredict_cnt),
`endif
        .flush          (flush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ref_taken(input logic ib, input logic [2:0] f3,
                                       input logic g, input logic e,
                                       input logic l, input logic u);
        if (!ib) return 1'b0;
        case (f3)
            3'd0: return e;
            3'd1: return !e;
            3'd4: return l;
            3'd5: return g | e;
            3'd6: return u;
            3'd7: return !u;
            default: return 1'b0;
        endcase
    endfunction

    task automatic stats_chk(input string tag);
`ifdef BRU_STATS_EN
        chk(tag, mispredict_cnt, exp_cnt);
`endif
    endtask

    task automatic drive(input logic ib, input logic [2:0] f3, input logic pt,
                         input logic [DW-1:0] p, input logic [DW-1:0] im,
                         input logic g, input logic e, input logic l,
                         input logic u);
        in_valid   = 1'b1;
        is_branch  = ib;
        funct3     = f3;
        pred_taken = pt;
        pc         = p;
        imm        = im;
        greater    = g;
        equal      = e;
        less       = l;
        ltu        = u;
    endtask

    task automatic check_res(input string tag, input logic t, input logic il,
                             input logic [DW-1:0] tgt, input logic [DW-1:0] rpc,
                             input logic rd);
        chk({tag, ".out_valid"}, out_valid, 1);
        chk({tag, ".taken"}, taken, t);
        chk({tag, ".illegal"}, illegal, il);
        chk({tag, ".target"}, target, tgt);
        chk({tag, ".redirect_pc"}, redirect_pc, rpc);
        chk({tag, ".redirect"}, redirect, rd);
        chk({tag, ".flush"}, flush, 0);
    endtask

    // One full transaction from IDLE back to IDLE, with a stall of
    // 'stall' cycles before out_ready rises.
    task automatic xact(input string tag, input logic ib, input logic [2:0] f3,
                        input logic pt, input logic [DW-1:0] p,
                        input logic [DW-1:0] im, input logic g, input logic e,
                        input logic l, input logic u, input int stall);
        logic          t;
        logic          il;
        logic          mp;
        logic [DW-1:0] tgt;
        logic [DW-1:0] rpc;
        t   = ref_taken(ib, f3, g, e, l, u);
        il  = ib && (f3 == 3'd2 || f3 == 3'd3);
        tgt = p + im;
        rpc = t ? tgt : p + 32'd4;
        mp  = t ^ pt;
        chk({tag, ".accept_ready"}, in_ready, 1);
        drive(ib, f3, pt, p, im, g, e, l, u);
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        if (mp && exp_cnt < 16'hFFFF) exp_cnt++;
        for (int s = 0; s < stall; s++) begin
            #1;
            check_res({tag, ".stall"}, t, il, tgt, rpc, mp && s == 0);
            chk({tag, ".stall_in_ready"}, in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check_res({tag, ".hs"}, t, il, tgt, rpc, mp && stall == 0);
        chk({tag, ".hs_in_ready"}, in_ready, !mp);
        stats_chk({tag, ".stats"});
        tick();
        out_ready = 1'b0;
        if (mp) begin
            for (int k = 0; k < FC; k++) begin
                in_valid = 1'b1;
                #1;
                chk({tag, ".flush"}, flush, 1);
                chk({tag, ".flush_in_ready"}, in_ready, 0);
                chk({tag, ".flush_out_valid"}, out_valid, 0);
                tick();
            end
            in_valid = 1'b0;
        end
        #1;
        chk({tag, ".end_flush"}, flush, 0);
        chk({tag, ".end_out_valid"}, out_valid, 0);
        chk({tag, ".end_in_ready"}, in_ready, 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 3'd0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.taken", taken, 0);
        chk("rst.illegal", illegal, 0);
        chk("rst.redirect", redirect, 0);
        chk("rst.flush", flush, 0);
        chk("rst.target", target, 0);
        chk("rst.redirect_pc", redirect_pc, 0);
        stats_chk("rst.stats");
        rst = 1'b0;
        tick();

        // BEQ taken, correctly predicted
        xact("beq", 1, 3'd0, 1, 32'h100, 32'h20, 0, 1, 0, 0, 0);
        // BLT not taken, predicted taken
        xact("blt", 1, 3'd4, 1, 32'h200, 32'h40, 1, 0, 0, 0, 0);
        chk("blt.rpc_const", redirect_pc, 32'h204);
        // BGEU taken with target wrap
        xact("bgeu", 1, 3'd7, 0, 32'hFFFF_FFF0, 32'h20, 0, 0, 0, 0, 0);
        chk("bgeu.wrap", target, 32'h10);

        // Four back-to-back correctly predicted BNE packets
        chk("b2b.ready0", in_ready, 1);
        out_ready = 1'b1;
        drive(1, 3'd1, 1, 32'h1000, 32'h40, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(1, 3'd1, 1, 32'h1000 + 32'(16 * (i + 1)),
                             32'h40, 0, 0, 1, 1);
            else in_valid = 1'b0;
            #1;
            check_res("b2b", 1, 0, 32'h1040 + 32'(16 * i),
                      32'h1040 + 32'(16 * i), 0);
            chk("b2b.in_ready", in_ready, 1);
            tick();
        end
        out_ready = 1'b0;
        #1;
        chk("b2b.done", out_valid, 0);

        // Stalled mispredict: redirect only in first HOLD cycle
        xact("stall", 1, 3'd5, 0, 32'h3000, 32'h80, 1, 0, 0, 0, 3);
        // Reserved funct3 and non-branch packets
        xact("ill", 1, 3'd2, 0, 32'h400, 32'h8, 1, 1, 1, 1, 0);
        xact("nobr", 0, 3'd2, 0, 32'h500, 32'h8, 1, 1, 1, 1, 1);

        // Reset during the second FLUSH cycle
        drive(1, 3'd4, 1, 32'h600, 32'h10, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        chk("rstfl.flush2", flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        chk("rstfl.flush", flush, 0);
        chk("rstfl.in_ready", in_ready, 1);
        chk("rstfl.out_valid", out_valid, 0);
        chk("rstfl.redirect", redirect, 0);
        chk("rstfl.taken", taken, 0);
        chk("rstfl.target", target, 0);
        chk("rstfl.redirect_pc", redirect_pc, 0);
        stats_chk("rstfl.stats");
        tick();

        // Randomized transactions
        for (int n = 0; n < 40; n++) begin
            logic [2:0] f;
            logic [3:0] fl;
            f  = 3'($urandom_range(0, 7));
            fl = 4'($urandom);
            xact("rnd", $urandom_range(0, 7) != 0, f, 1'($urandom),
                 DW'($urandom), DW'($urandom), fl[0], fl[1], fl[2], fl[3],
                 $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of pc, imm, target and redirect_pc.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..15: number of cycles flush stays high after a mispredict.
REQ-003 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 in_valid  input  1  upstream has a branch packet.
REQ-007 in_ready  output  1  block accepts a packet this cycle.
REQ-008 is_branch  input  1  packet is a conditional branch.
REQ-009 funct3  input  3  branch condition code.
REQ-010 pred_taken  input  1  fetch-stage prediction.
REQ-011 pc, imm  input  DATA_WIDTH each  instruction address; sign-extended offset.
REQ-012 greater, equal, less  input  1 each  signed compare flags from ALU_Comparator for rs1 vs rs2.
REQ-013 ltu  input  1  unsigned rs1 < rs2.
REQ-014 out_valid  output  1  registered result available.
REQ-015 out_ready  input  1  downstream consumes the result.
REQ-016 taken, illegal  output  1 each  resolved direction; reserved funct3 seen.
REQ-017 target  output  DATA_WIDTH  pc+imm, registered.
REQ-018 redirect  output  1  one-cycle mispredict pulse.
REQ-019 redirect_pc  output  DATA_WIDTH  correct next pc.
REQ-020 flush  output  1  squash younger instructions.

Function
REQ-021 Condition decode: 000 equal; 001 !equal; 100 less; 101 greater|equal; 110 ltu; 111 !ltu; 010/011 taken=0 and illegal=1.
REQ-022 is_branch=0: taken=0 and illegal=0 regardless of funct3.
REQ-023 target = pc+imm, modulo 2^DATA_WIDTH, with no overflow flag; redirect_pc = taken ? target : pc+4, modulo 2^DATA_WIDTH.
REQ-024 Mispredict = taken XOR pred_taken, evaluated on the accepted packet.
REQ-025 States: IDLE, HOLD, FLUSH.
REQ-026 Accept occurs when in_valid&&in_ready at a rising edge; outputs are registered, giving latency 1 cycle.
REQ-027 IDLE: in_ready=1; on accept, go to HOLD.
REQ-028 HOLD: out_valid=1; outputs remain stable until out_ready=1.
REQ-029 Handshake without mispredict: on out_ready, go to IDLE, or stay in HOLD with a new packet if one is accepted the same cycle.
REQ-030 Handshake with mispredict: on out_ready, go to FLUSH.
REQ-031 In HOLD, in_ready = out_ready && !mispredict_reg, so a back-to-back non-mispredict stream runs at full throughput.
REQ-032 redirect=1 only in the first cycle of HOLD for a mispredicting packet, even if HOLD is stalled by out_ready=0.
REQ-033 FLUSH: flush=1, in_ready=0, out_valid=0; a down-counter loaded with FLUSH_CYCLES-1 returns the state to IDLE after exactly FLUSH_CYCLES cycles.
REQ-034 in_valid=1 during FLUSH is ignored, with no accept.
REQ-035 Multiple comparator flags high: the decode uses the flags exactly as given, with no checking.

Reset
REQ-036 rst=1 forces state IDLE and flush counter 0.
REQ-037 rst=1 drives out_valid, taken, illegal, redirect and flush to 0.
REQ-038 rst=1 drives target and redirect_pc to 0.
REQ-039 rst=1 clears mispredict_cnt to 0.
REQ-040 Reset mid-HOLD or mid-FLUSH drops the pending result and flush with no redirect pulse; in_ready=1 the cycle after rst deasserts.

Configuration
REQ-041 Macro BRU_STATS_EN defined: adds output mispredict_cnt [15:0], which increments once per accepted mispredicting packet and saturates at 0xFFFF.
REQ-042 Macro BRU_STATS_EN undefined: the port and counter do not exist; all other behaviour is identical.

Structure
REQ-043 Package bru_pkg holds the funct3 localparams (BEQ..BGEU), the state enum bru_state_t, and the FLUSH_CYCLES default.
REQ-044 The combinational decode (REQ-021/022) is sub-module branch_cond_decode; the FSM, registers and counter live in the top.

Verification
REQ-045 BEQ, equal=1, pred_taken=1, pc=0x100, imm=0x20 -> next cycle out_valid=1, taken=1, target=0x120, redirect=0, flush never asserted.
REQ-046 BLT, less=0, pred_taken=1, pc=0x200 -> redirect=1 for 1 cycle, redirect_pc=0x204; after out_ready, flush=1 for exactly 2 cycles with in_ready=0; mispredict_cnt=1 when BRU_STATS_EN is defined.
REQ-047 BGEU, ltu=0, pc=0xFFFFFFF0, imm=0x20, pred_taken=0 -> taken=1, target=0x00000010 (wrap), redirect=1.
REQ-048 Four back-to-back correctly predicted BNE packets with out_ready=1 -> 4 results on 4 consecutive cycles with in_ready held 1.
REQ-049 out_ready=0 for 3 cycles on a mispredicting packet -> outputs stable, redirect high only in the first cycle; funct3=010 -> illegal=1, taken=0.
REQ-050 rst asserted during the second FLUSH cycle -> flush=0 and in_ready=1 the cycle after rst deasserts; all outputs 0.
